// File: rtl/ctrl_alu.sv
// ctrl_alu: main decoder, ALU decoder and 32-bit ALU for a single-cycle RV32I
// core (lw, sw, R-type, I-type ALU, beq, jal).
// Optional build macro CTRL_ALU_EXT_OPS_EN adds xor, sll and srl/sra decodes
// under ALUOp 10; without it those funct3 values decode to add and are
// flagged as unsupported.
//
// Handshake: none. This block has no valid/ready pair; every cycle carries
// exactly one instruction, and all outputs except the sticky illegal flag are
// combinational functions of the current inputs.
module ctrl_alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] rd,
    output logic        z,
    output logic        PCSrc,
    output logic        MemWrite,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ResultSrc,
    output logic [2:0]  ALUControl,
    output logic        illegal
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SR  = 3'b111;

    // Raw decode before reset gating of the state-changing enables.
    logic       dec_regwrite;
    logic       dec_memwrite;
    logic       branch;
    logic       jump;
    logic [1:0] aluop;
    logic       op_bad;
    logic       f3_bad;
    logic       sub_sel;
    logic       unsupported;

    // Main decoder: opcode to datapath controls; unknown opcodes give all zero.
    always_comb begin
        dec_regwrite = 1'b0;
        ImmSrc       = 2'b00;
        ALUSrc       = 1'b0;
        dec_memwrite = 1'b0;
        ResultSrc    = 2'b00;
        branch       = 1'b0;
        aluop        = 2'b00;
        jump         = 1'b0;
        op_bad       = 1'b0;
        case (op)
            OP_LW: begin
                dec_regwrite = 1'b1;
                ALUSrc       = 1'b1;
                ResultSrc    = 2'b01;
            end
            OP_SW: begin
                ImmSrc       = 2'b01;
                ALUSrc       = 1'b1;
                dec_memwrite = 1'b1;
            end
            OP_R: begin
                dec_regwrite = 1'b1;
                aluop        = 2'b10;
            end
            OP_I: begin
                dec_regwrite = 1'b1;
                ALUSrc       = 1'b1;
                aluop        = 2'b10;
            end
            OP_BEQ: begin
                ImmSrc       = 2'b10;
                branch       = 1'b1;
                aluop        = 2'b01;
            end
            OP_JAL: begin
                dec_regwrite = 1'b1;
                ImmSrc       = 2'b11;
                ResultSrc    = 2'b10;
                jump         = 1'b1;
            end
            default: op_bad = 1'b1;
        endcase
    end

    // funct7 only means sub/sra for register-register ops; addi/srai keep
    // their immediate bits out of the operation select via op[5].
    assign sub_sel = op[5] & funct7;

    // ALU decoder: ALUOp plus funct fields to the ALU operation code.
    always_comb begin
        ALUControl = ALU_ADD;
        f3_bad     = 1'b0;
        case (aluop)
            2'b00: ALUControl = ALU_ADD;
            2'b01: ALUControl = ALU_SUB;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = sub_sel ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
`ifdef CTRL_ALU_EXT_OPS_EN
                    3'b100:  ALUControl = ALU_XOR;
                    3'b001:  ALUControl = ALU_SLL;
                    3'b101:  ALUControl = ALU_SR;
`endif
                    default: begin
                        ALUControl = ALU_ADD;
                        f3_bad     = 1'b1;
                    end
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

    // ALU datapath; codes without an operation in this build give zero.
    always_comb begin
        rd = 32'd0;
        case (ALUControl)
            ALU_ADD: rd = rs1 + rs2;
            ALU_SUB: rd = rs1 - rs2;
            ALU_AND: rd = rs1 & rs2;
            ALU_OR:  rd = rs1 | rs2;
            ALU_SLT: rd = {31'd0, ($signed(rs1) < $signed(rs2))};
`ifdef CTRL_ALU_EXT_OPS_EN
            ALU_XOR: rd = rs1 ^ rs2;
            ALU_SLL: rd = rs1 << rs2[4:0];
            ALU_SR:  rd = sub_sel ? 32'($signed(rs1) >>> rs2[4:0])
                                  : (rs1 >> rs2[4:0]);
`endif
            default: rd = 32'd0;
        endcase
    end

    assign z = ~|rd;

    // Enables that change architectural state are held off while in reset,
    // independent of the clock.
    assign RegWrite = dec_regwrite & rst_n;
    assign MemWrite = dec_memwrite & rst_n;
    assign PCSrc    = ((branch & z) | jump) & rst_n;

    assign unsupported = op_bad | f3_bad;

    // Sticky unsupported-instruction flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal <= 1'b0;
        end else if (unsupported) begin
            illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ctrl_alu.sv
// tb_ctrl_alu: directed-vector bench for ctrl_alu. The driver applies one
// instruction per cycle just after the rising edge and queues the
// hand-computed response; the monitor pops and compares on the falling edge.
module tb_ctrl_alu;

    localparam int W = 45;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rd;
    logic        z;
    logic        PCSrc;
    logic        MemWrite;
    logic        ALUSrc;
    logic        RegWrite;
    logic [1:0]  ImmSrc;
    logic [1:0]  ResultSrc;
    logic [2:0]  ALUControl;
    logic        illegal;

    ctrl_alu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7     (funct7),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .z          (z),
        .PCSrc      (PCSrc),
        .MemWrite   (MemWrite),
        .ALUSrc     (ALUSrc),
        .RegWrite   (RegWrite),
        .ImmSrc     (ImmSrc),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .illegal    (illegal)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;

    // Packed view: {illegal, PCSrc, MemWrite, ALUSrc, RegWrite, ImmSrc,
    //               ResultSrc, ALUControl, z, rd}
    function automatic logic [W-1:0] pack(input logic il, input logic pc,
                                          input logic mw, input logic as,
                                          input logic rw, input logic [1:0] imm,
                                          input logic [1:0] res,
                                          input logic [2:0] alc,
                                          input logic zz, input logic [31:0] r);
        return {il, pc, mw, as, rw, imm, res, alc, zz, r};
    endfunction

    // ---------------- driver ----------------
    task automatic step(input string nm, input logic rstv, input logic [6:0] o,
                        input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [W-1:0] expv);
        @(posedge clk);
        #1;
        rst_n  = rstv;
        op     = o;
        funct3 = f3;
        funct7 = f7;
        rs1    = a;
        rs2    = b;
        exp_q.push_back(expv);
        name_q.push_back(nm);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [W-1:0] e;
            logic [W-1:0] act;
            string        nm;
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = pack(illegal, PCSrc, MemWrite, ALUSrc, RegWrite, ImmSrc,
                       ResultSrc, ALUControl, z, rd);
            n_cmp++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL %s: got {il,pc,mw,as,rw,imm,res,alc,z}=%b rd=%h, want %b rd=%h",
                         nm, act[W-1:32], act[31:0], e[W-1:32], e[31:0]);
            end
        end
    end

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    // ---------------- stimulus ----------------
    initial begin
        int waited;
        rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7 = 1'b0;
        rs1 = 32'd0; rs2 = 32'd0;

        // Reset state: opcode 0 decodes to nothing, add 0+0.
        step("reset", 1'b0, 7'd0, 3'd0, 1'b0, 32'd0, 32'd0,
             pack(0,0,0,0,0,2'b00,2'b00,3'b000,1,32'd0));

        step("lw", 1'b1, LW, 3'b010, 1'b0, 32'd100, 32'd20,
             pack(0,0,0,1,1,2'b00,2'b01,3'b000,0,32'd120));
        step("sw_zero", 1'b1, SW, 3'b010, 1'b0, 32'h10, 32'hFFFF_FFF0,
             pack(0,0,1,1,0,2'b01,2'b00,3'b000,1,32'd0));
        step("r_add", 1'b1, RT, 3'b000, 1'b0, 32'd7, 32'd9,
             pack(0,0,0,0,1,2'b00,2'b00,3'b000,0,32'd16));
        step("r_sub_eq", 1'b1, RT, 3'b000, 1'b1, 32'd5, 32'd5,
             pack(0,0,0,0,1,2'b00,2'b00,3'b001,1,32'd0));
        step("r_sub_neg", 1'b1, RT, 3'b000, 1'b1, 32'd3, 32'd5,
             pack(0,0,0,0,1,2'b00,2'b00,3'b001,0,32'hFFFF_FFFE));
        step("slt_neg_lt", 1'b1, RT, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1,
             pack(0,0,0,0,1,2'b00,2'b00,3'b101,0,32'd1));
        step("slt_pos_ge", 1'b1, RT, 3'b010, 1'b0, 32'd1, 32'hFFFF_FFFF,
             pack(0,0,0,0,1,2'b00,2'b00,3'b101,1,32'd0));
        step("slt_min_max", 1'b1, RT, 3'b010, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF,
             pack(0,0,0,0,1,2'b00,2'b00,3'b101,0,32'd1));
        step("r_or", 1'b1, RT, 3'b110, 1'b0, 32'hF0F0_0000, 32'h0000_0F0F,
             pack(0,0,0,0,1,2'b00,2'b00,3'b011,0,32'hF0F0_0F0F));
        step("r_and", 1'b1, RT, 3'b111, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F,
             pack(0,0,0,0,1,2'b00,2'b00,3'b010,0,32'h0F00_0F00));
        step("addi_f7_wrap", 1'b1, IT, 3'b000, 1'b1, 32'hFFFF_FFFF, 32'd1,
             pack(0,0,0,1,1,2'b00,2'b00,3'b000,1,32'd0));
        step("jal", 1'b1, JAL, 3'b000, 1'b0, 32'd0, 32'd0,
             pack(0,1,0,0,1,2'b11,2'b10,3'b000,1,32'd0));
        step("beq_taken", 1'b1, BEQ, 3'b000, 1'b0, 32'd7, 32'd7,
             pack(0,1,0,0,0,2'b10,2'b00,3'b001,1,32'd0));
        step("beq_not_taken", 1'b1, BEQ, 3'b000, 1'b0, 32'd7, 32'd8,
             pack(0,0,0,0,0,2'b10,2'b00,3'b001,0,32'hFFFF_FFFF));
`ifdef CTRL_ALU_EXT_OPS_EN
        step("r_xor", 1'b1, RT, 3'b100, 1'b0, 32'hF0, 32'hFF,
             pack(0,0,0,0,1,2'b00,2'b00,3'b100,0,32'h0F));
        step("after_xor", 1'b1, LW, 3'b010, 1'b0, 32'd1, 32'd2,
             pack(0,0,0,1,1,2'b00,2'b01,3'b000,0,32'd3));
`else
        // Unsupported funct3 decodes to add; flag appears after the edge.
        step("f3_100_as_add", 1'b1, RT, 3'b100, 1'b0, 32'hF0, 32'hFF,
             pack(0,0,0,0,1,2'b00,2'b00,3'b000,0,32'h1EF));
        step("f3_100_sticky", 1'b1, LW, 3'b010, 1'b0, 32'd1, 32'd2,
             pack(1,0,0,1,1,2'b00,2'b01,3'b000,0,32'd3));
`endif
        // Async reset: flag clears and enables drop before any clock edge.
        step("jal_in_reset", 1'b0, JAL, 3'b000, 1'b0, 32'd0, 32'd0,
             pack(0,0,0,0,0,2'b11,2'b10,3'b000,1,32'd0));
        // Release with an illegal opcode: no edge yet, so flag still clear.
        step("bad_op_release", 1'b1, BAD, 3'b000, 1'b0, 32'd2, 32'd3,
             pack(0,0,0,0,0,2'b00,2'b00,3'b000,0,32'd5));
        step("bad_op_sticky", 1'b1, BAD, 3'b000, 1'b0, 32'd2, 32'd3,
             pack(1,0,0,0,0,2'b00,2'b00,3'b000,0,32'd5));
        step("bad_op_reset", 1'b0, BAD, 3'b000, 1'b0, 32'd0, 32'd0,
             pack(0,0,0,0,0,2'b00,2'b00,3'b000,1,32'd0));

        // ---------------- final report ----------------
        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected responses left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ctrl_alu.md
# ctrl_alu

Combined control unit and 32-bit ALU for the single-cycle RV32I core, covering lw, sw, R-type, I-type ALU, beq and jal. The main decoder and ALU decoder turn `op`/`funct3`/`funct7` into datapath control signals, and the ALU computes the result and zero flag. The zero flag feeds the branch decision in the same cycle. The ALUSrc operand mux, register file, memories and immediate extender live outside this block.

## Interface
Parameters:
- none (fixed 32-bit datapath)

Ports:
- `clk`  in  1  core clock; one clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `op`  in  7  instruction opcode, bits [6:0].
- `funct3`  in  3  instruction bits [14:12].
- `funct7`  in  1  instruction bit 30 (sub/sra select).
- `rs1`  in  32  ALU operand A.
- `rs2`  in  32  ALU operand B, already muxed externally by ALUSrc.
- `rd`  out  32  ALU result.
- `z`  out  1  high when `rd == 0`.
- `PCSrc`  out  1  high selects PC+imm.
- `MemWrite`  out  1  data memory write enable.
- `ALUSrc`  out  1  high selects the immediate as operand B.
- `RegWrite`  out  1  register file write enable.
- `ImmSrc`  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- `ResultSrc`  out  2  writeback select: 00 ALU, 01 memory, 10 PC+4.
- `ALUControl`  out  3  ALU operation code.
- `illegal`  out  1  sticky unsupported-instruction flag.

## Operation
Main decoder (combinational). Signals listed as RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump:
- lw 0000011: 1, 00, 1, 0, 01, 0, 00, 0
- sw 0100011: 0, 01, 1, 1, 00, 0, 00, 0
- R 0110011: 1, 00, 0, 0, 00, 0, 10, 0
- I-ALU 0010011: 1, 00, 1, 0, 00, 0, 10, 0
- beq 1100011: 0, 10, 0, 0, 00, 1, 01, 0
- jal 1101111: 1, 11, 0, 0, 10, 0, 00, 1
- any other opcode: all zero; counts as unsupported.

PC select:
- `PCSrc = (Branch & z) | Jump`.

ALU decoder, selected by ALUOp:
- ALUOp 00 → 000 (add).
- ALUOp 01 → 001 (sub).
- ALUOp 10 with funct3 000 → 001 if `op[5] & funct7`, else 000. addi with funct7=1 therefore stays add.
- ALUOp 10 with funct3 010 → 101 (slt).
- ALUOp 10 with funct3 110 → 011 (or).
- ALUOp 10 with funct3 111 → 010 (and).
- ALUOp 10 with any other funct3 → 000; counts as unsupported unless enabled by the Configuration section.

ALU operations, all mod 2^32:
- 000 `rs1+rs2`
- 001 `rs1-rs2`
- 010 and
- 011 or
- 101 signed `rs1<rs2` result, zero-extended to 32 bits.
- Unused codes produce 0.
- `z` is the NOR of all bits of `rd`.

Reset gating:
- While `rst_n`=0, `RegWrite`, `MemWrite` and `PCSrc` are forced to 0 asynchronously.
- All other outputs continue to follow decode.

Illegal flag:
- `illegal` is set on a rising `clk` when the current instruction is unsupported.
- It holds until reset.

## Timing
- Decode, ALU, `z` and `PCSrc` are purely combinational with zero-cycle latency.
- All outputs are valid within the same cycle `op`, `funct3`, `funct7`, `rs1` and `rs2` settle.
- The only state is `illegal`:
  - reset value 0;
  - it clears immediately when `rst_n` falls;
  - it captures on rising `clk` once `rst_n`=1.
- If reset is deasserted in the same cycle as an unsupported instruction, the flag sets on the first `clk` edge after deassertion.
- There is no handshake: one instruction is handled per cycle.

## Configuration
- `CTRL_ALU_EXT_OPS_EN` defined adds these ALUOp 10 decodes, none of which is unsupported:
  - funct3 100 → ALUControl 100, `rs1^rs2`;
  - funct3 001 → 110, `rs1 << rs2[4:0]`;
  - funct3 101 → 111, logical right shift by `rs2[4:0]`; with `op[5] & funct7` instead, arithmetic right shift, still code 111.
- Without the macro:
  - those funct3 values decode to 000 (add) and set `illegal`;
  - ALUControl codes 100, 110 and 111 produce 0.

## Test plan
- op=0000011 (lw), `rst_n`=1 → RegWrite=1, ImmSrc=00, ALUSrc=1, MemWrite=0, ResultSrc=01, ALUControl=000, PCSrc=0.
- op=0100011 (sw) → RegWrite=0, ImmSrc=01, ALUSrc=1, MemWrite=1, ALUControl=000, PCSrc=0.
- R-type checks, with ResultSrc=00 throughout:
  - funct3=000, funct7=0 → ALUControl=000, RegWrite=1, ALUSrc=0.
  - funct7=1 → ALUControl=001.
  - rs1=5, rs2=5 → rd=0, z=1.
- I-type and jal checks:
  - op=0010011, funct3=000, funct7=1 → ALUControl=000, ImmSrc=00, ALUSrc=1, ResultSrc=00.
  - op=1101111 → RegWrite=1, ImmSrc=11, ResultSrc=10, PCSrc=1.
- beq checks (op=1100011):
  - rs1=rs2=7 → z=1, PCSrc=1, ImmSrc=10, ALUSrc=0, RegWrite=0, MemWrite=0.
  - rs1=7, rs2=8 → PCSrc=0.
- Reset and illegal flag:
  - op=1111111 with rst_n=1, then one clk edge → `illegal`=1.
  - Drop rst_n → `illegal`=0 immediately.
  - jal during reset → PCSrc=0, RegWrite=0.
